xnorgate: RTL and testbench
===========================

XNORGATE -- requirements
Module: xnorgate

Interface
- REQ-001: Parameter WIDTH SHALL be declared: default 1, operand width in bits, legal range 1..64.
- REQ-002: Parameter CNT_W SHALL be declared: default 16, width of the statistics counters, legal range 4..32.
- REQ-003: Port clk SHALL be an input, 1 bit wide: the single clock; all state SHALL update on its rising edge.
- REQ-004: Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
- REQ-005: Port in_valid SHALL be an input, 1 bit wide: qualifies a and b in the current cycle.
- REQ-006: Port a SHALL be an input, WIDTH bits wide: first operand.
- REQ-007: Port b SHALL be an input, WIDTH bits wide: second operand.
- REQ-008: Port c SHALL be an output, WIDTH bits wide: registered bitwise XNOR of a and b.
- REQ-009: Port out_valid SHALL be an output, 1 bit wide: c, eq and match_cnt hold a new result this cycle.
- REQ-010: Port eq SHALL be an output, 1 bit wide: registered flag, all bits of a equal b.
- REQ-011: Port match_cnt SHALL be an output, $clog2(WIDTH+1) bits wide: registered count of equal bit positions.
- REQ-012: Port eq_count SHALL be an output, CNT_W bits wide: number of accepted samples with eq=1.
- REQ-013: Port total_count SHALL be an output, CNT_W bits wide: number of accepted samples.

Function
- REQ-014: A sample SHALL be accepted on a rising clk edge where in_valid=1 and rst=0.
- REQ-015: On acceptance, c SHALL load ~(a ^ b) bit by bit; latency is exactly 1 cycle.
- REQ-016: On acceptance, eq SHALL load the AND-reduction of ~(a ^ b).
- REQ-017: On acceptance, match_cnt SHALL load the popcount of ~(a ^ b).
- REQ-018: out_valid SHALL be 1 in the cycle after an acceptance and 0 otherwise; it is a single-cycle pulse per sample.
- REQ-019: When no sample is accepted, c, eq and match_cnt SHALL hold their previous values.
- REQ-020: Back-to-back in_valid SHALL be accepted every cycle with no stall; there is no backpressure.
- REQ-021: Truth table per bit: 00->1, 01->0, 10->0, 11->1.
- REQ-022: In 4-state simulation, an x or z on a[i] or b[i] SHALL yield x on c[i]; eq and match_cnt may be x for that sample; the counters SHALL NOT be corrupted beyond that sample's increment decision.
- REQ-023: Counters SHALL saturate at all-ones and SHALL never wrap.

Reset
- REQ-024: While rst=1 at a clk edge, the outputs SHALL take these values: c=0, eq=0, match_cnt=0, out_valid=0, eq_count=0, total_count=0.
- REQ-025: rst SHALL take priority over a simultaneous in_valid; that sample is dropped.
- REQ-026: Reset asserted mid-stream SHALL clear state in the same edge; the first post-reset result SHALL appear 1 cycle after the first accepted sample.

Configuration
- REQ-027: Macro XNORGATE_STATS_EN defined SHALL enable counting: total_count increments per accepted sample and eq_count increments per accepted sample with eq=1, both saturating.
- REQ-028: Macro XNORGATE_STATS_EN undefined SHALL remove the counter logic and tie eq_count and total_count to 0; all other behaviour is unchanged.

Structure
- REQ-029: Package xnorgate_pkg SHALL hold the WIDTH and CNT_W default constants and the match_cnt width calculation.
- REQ-030: Sub-module xnorgate_popcount SHALL hold the combinational popcount of a WIDTH-bit vector; the top SHALL instantiate it once.

Verification
- REQ-031: WIDTH=1, in_valid=1, (a,b)=00,01,10,11 on successive cycles -> c=1,0,0,1, each one cycle later, with out_valid=1 each cycle.
- REQ-032: WIDTH=4, a=4'b1010, b=4'b1001 accepted -> next cycle c=4'b1100, match_cnt=2, eq=0.
- REQ-033: WIDTH=4, a=b=4'hF accepted, then in_valid=0 for 3 cycles -> c=4'hF, eq=1, match_cnt=4 held; out_valid high 1 cycle only.
- REQ-034: STATS_EN, CNT_W=4, 20 accepted equal samples -> eq_count=15 and total_count=15, saturated; rst pulse -> both 0 next cycle.
- REQ-035: rst=1 together with in_valid=1, a=0, b=0 -> next cycle c=0, out_valid=0, total_count unchanged at 0.
- REQ-036: WIDTH=1 simulation, a=x, b=1 -> c=x; then a=1, b=0 -> c=0, demonstrating recovery.

Source files
------------

// File: rtl/xnorgate_pkg.sv
// Shared defaults and width helpers for the xnorgate block.
package xnorgate_pkg;

    localparam int unsigned XNOR_WIDTH_DEFAULT = 1;
    localparam int unsigned XNOR_CNT_W_DEFAULT = 16;

    // Bits needed to hold a popcount in the range 0..width.
    function automatic int unsigned match_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/xnorgate_popcount.sv
// Combinational popcount of a WIDTH-bit vector.
module xnorgate_popcount
    import xnorgate_pkg::*;
#(
    parameter int unsigned WIDTH = XNOR_WIDTH_DEFAULT,
    parameter int unsigned OUT_W = match_w(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [OUT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt = cnt + OUT_W'(vec[i]);
        end
    end

endmodule

// File: rtl/xnorgate.sv
// Registered bitwise XNOR with equality flag, match count and optional
// saturating statistics counters (enabled by XNORGATE_STATS_EN).
module xnorgate
    import xnorgate_pkg::*;
#(
    parameter int unsigned WIDTH = XNOR_WIDTH_DEFAULT,
    parameter int unsigned CNT_W = XNOR_CNT_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    output logic [WIDTH-1:0]            c,
    output logic                        out_valid,
    output logic                        eq,
    output logic [match_w(WIDTH)-1:0]   match_cnt,
    output logic [CNT_W-1:0]            eq_count,
    output logic [CNT_W-1:0]            total_count
);

    localparam int unsigned MW = match_w(WIDTH);

    logic [WIDTH-1:0] xn;
    logic [MW-1:0]    pop;
    logic             eq_next;

    assign xn      = ~(a ^ b);
    assign eq_next = &xn;

    xnorgate_popcount #(
        .WIDTH (WIDTH),
        .OUT_W (MW)
    ) u_popcount (
        .vec (xn),
        .cnt (pop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            c         <= '0;
            eq        <= 1'b0;
            match_cnt <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c         <= xn;
                eq        <= eq_next;
                match_cnt <= pop;
            end
        end
    end

`ifdef XNORGATE_STATS_EN
    // An unknown eq_next never takes the increment branch, so an x sample
    // cannot poison eq_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            eq_count    <= '0;
            total_count <= '0;
        end else if (in_valid) begin
            if (total_count != '1) begin
                total_count <= total_count + CNT_W'(1);
            end
            if (eq_next && (eq_count != '1)) begin
                eq_count <= eq_count + CNT_W'(1);
            end
        end
    end
`else
    assign eq_count    = '0;
    assign total_count = '0;
`endif

endmodule

// File: tb/tb_xnorgate.sv
// Randomized self-checking bench for xnorgate (WIDTH=4 and WIDTH=1 instances).
module tb_xnorgate;

`ifdef XNORGATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int CMAX = 15;
    localparam int SAT  = STATS ? CMAX : 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv4, iv1;
    logic [3:0] a4, b4;
    logic       a1, b1;

    logic [3:0] c4;
    logic       ov4, eq4;
    logic [2:0] m4;
    logic [3:0] eqc4_d, tot4_d;
    logic       c1, ov1, eq1;
    logic [0:0] m1;
    logic [3:0] eqc1_d, tot1_d;

    xnorgate #(.WIDTH(4), .CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4),
        .c(c4), .out_valid(ov4), .eq(eq4), .match_cnt(m4),
        .eq_count(eqc4_d), .total_count(tot4_d)
    );

    xnorgate #(.WIDTH(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1),
        .c(c1), .out_valid(ov1), .eq(eq1), .match_cnt(m1),
        .eq_count(eqc1_d), .total_count(tot1_d)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [3:0] m_c4;
    bit         m_v4, m_e4;
    int         m_m4, tot4, eqc4;
    logic       m_c1;
    bit         m_v1, m_e1;
    int         tot1, eqc1;
    bit         xs1, amb1;

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit v4, input logic [3:0] av4,
                                input logic [3:0] bv4, input bit v1,
                                input logic av1, input logic bv1);
        int n;
        if (r) begin
            m_c4 = '0; m_v4 = 0; m_e4 = 0; m_m4 = 0; tot4 = 0; eqc4 = 0;
            m_c1 = 1'b0; m_v1 = 0; m_e1 = 0; tot1 = 0; eqc1 = 0;
            xs1 = 0; amb1 = 0;
            return;
        end
        m_v4 = v4;
        if (v4) begin
            n = 0;
            for (int i = 0; i < 4; i++) begin
                m_c4[i] = (av4[i] == bv4[i]);
                if (av4[i] == bv4[i]) n++;
            end
            m_m4 = n;
            m_e4 = (n == 4);
            if (STATS) begin
                tot4 = sat_inc(tot4);
                if (m_e4) eqc4 = sat_inc(eqc4);
            end
        end
        m_v1 = v1;
        if (v1) begin
            if ((av1 ^ bv1) === 1'bx) begin
                m_c1 = 1'bx;
                xs1  = 1;
                if (STATS) amb1 = 1;
            end else begin
                xs1  = 0;
                m_c1 = (av1 == bv1);
                m_e1 = (av1 == bv1);
                if (STATS && m_e1) eqc1 = sat_inc(eqc1);
            end
            if (STATS) tot1 = sat_inc(tot1);
        end
    endtask

    task automatic compare_all();
        chk("c4", 64'(c4), 64'(m_c4));
        chk("out_valid4", 64'(ov4), 64'(m_v4));
        chk("eq4", 64'(eq4), 64'(m_e4));
        chk("match_cnt4", 64'(m4), 64'(m_m4));
        chk("total_count4", 64'(tot4_d), 64'(tot4));
        chk("eq_count4", 64'(eqc4_d), 64'(eqc4));
        chk("c1", 64'(c1), 64'(m_c1));
        chk("out_valid1", 64'(ov1), 64'(m_v1));
        if (!xs1) begin
            chk("eq1", 64'(eq1), 64'(m_e1));
            chk("match_cnt1", 64'(m1), 64'(m_e1));
        end
        chk("total_count1", 64'(tot1_d), 64'(tot1));
        if (amb1) begin
            total++;
            if (!(eqc1_d === 4'(eqc1) || eqc1_d === 4'(sat_inc(eqc1)))) begin
                bad++;
                $display("FAIL eq_count1 actual=%0d required=%0d or %0d", eqc1_d, eqc1, sat_inc(eqc1));
            end
        end else begin
            chk("eq_count1", 64'(eqc1_d), 64'(eqc1));
        end
    endtask

    task automatic step(input bit r, input bit v4, input logic [3:0] av4,
                        input logic [3:0] bv4, input bit v1,
                        input logic av1, input logic bv1);
        rst = r; iv4 = v4; a4 = av4; b4 = bv4; iv1 = v1; a1 = av1; b1 = bv1;
        @(posedge clk);
        model_update(r, v4, av4, bv4, v1, av1, bv1);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic [1:0] pair;
        rst = 1; iv4 = 0; iv1 = 0; a4 = '0; b4 = '0; a1 = 0; b1 = 0;

        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        chk("reset_c4", 64'(c4), 64'd0);
        chk("reset_total4", 64'(tot4_d), 64'd0);

        // reset wins over a simultaneous sample
        step(1, 1, 4'h0, 4'h0, 1, 0, 0);
        chk("rst_prio_c4", 64'(c4), 64'd0);
        chk("rst_prio_ov4", 64'(ov4), 64'd0);
        chk("rst_prio_total4", 64'(tot4_d), 64'd0);

        // WIDTH=1 truth table, back-to-back
        for (int i = 0; i < 4; i++) begin
            pair = 2'(i);
            step(0, 0, 4'h0, 4'h0, 1, pair[1], pair[0]);
            chk($sformatf("tt_c1_%0d", i), 64'(c1), (i == 0 || i == 3) ? 64'd1 : 64'd0);
            chk($sformatf("tt_ov1_%0d", i), 64'(ov1), 64'd1);
        end

        step(0, 1, 4'b1010, 4'b1001, 0, 0, 0);
        chk("lit_c4", 64'(c4), 64'b1100);
        chk("lit_match4", 64'(m4), 64'd2);
        chk("lit_eq4", 64'(eq4), 64'd0);

        step(0, 1, 4'hF, 4'hF, 0, 0, 0);
        chk("hold_ov_first", 64'(ov4), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'h3, 4'h5, 0, 0, 0);
            chk("hold_c4", 64'(c4), 64'hF);
            chk("hold_eq4", 64'(eq4), 64'd1);
            chk("hold_match4", 64'(m4), 64'd4);
            chk("hold_ov4", 64'(ov4), 64'd0);
        end

        // saturation of counters
        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom);
            step(0, 1, ra, ra, 1, ra[0], ra[0]);
        end
        chk("sat_eq_count4", 64'(eqc4_d), 64'(SAT));
        chk("sat_total4", 64'(tot4_d), 64'(SAT));
        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        chk("sat_clr_eq_count4", 64'(eqc4_d), 64'd0);
        chk("sat_clr_total4", 64'(tot4_d), 64'd0);

        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? ra : 4'($urandom);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, ra, rb,
                 $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
        end

        // unknown operand and recovery
        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        step(0, 0, 4'h0, 4'h0, 1, 1'bx, 1'b1);
        chk("x_c1", 64'(c1), 64'(1'bx));
        step(0, 0, 4'h0, 4'h0, 1, 1'b1, 1'b0);
        chk("x_recover_c1", 64'(c1), 64'd0);
        step(0, 0, 4'h0, 4'h0, 1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
